edge_det_filt: RTL and testbench
================================

EDGE_DET_FILT -- requirements
Module: edge_det_filt

Interface
REQ-001 The block SHALL have parameter NCH, default 4, giving the number of independent input channels (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchroniser flops per channel (2..4).
REQ-003 The block SHALL have parameter FILT_W, default 4, giving the width of the glitch-filter threshold and counter.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; one clock, synchronous and active-high.
REQ-006 sig  input  NCH  asynchronous input levels, one bit per channel.
REQ-007 mode  input  2  edge select, common to all channels: 00 none, 01 rising, 10 falling, 11 both.
REQ-008 filt_len  input  FILT_W  consecutive stable cycles required before a level change is accepted; value 0 SHALL behave as 1.
REQ-009 clr  input  NCH  per-channel sticky-flag clear, level-sensitive.
REQ-010 level  output  NCH  filtered, synchronised level per channel.
REQ-011 pulse  output  NCH  registered one-cycle event strobe per channel.
REQ-012 sticky  output  NCH  per-channel latched event flag.
REQ-013 any_pulse  output  1  registered OR of all pulse bits, coincident with pulse.

Function
REQ-014 Each channel SHALL pass sig through SYNC_STAGES flops; the last stage is the synchronised value s.
REQ-015 While s equals level, the channel counter SHALL be held at 0.
REQ-016 While s differs from level, the counter SHALL increment each cycle; when counter+1 reaches max(filt_len,1), level SHALL take s and the counter SHALL return to 0 on the same edge.
REQ-017 A difference lasting fewer than max(filt_len,1) consecutive cycles SHALL be discarded with no change to level, pulse or sticky.
REQ-018 The counter SHALL never exceed max(filt_len,1)-1 and SHALL never wrap.
REQ-019 pulse SHALL be high for exactly the one cycle in which level shows its new value, and only if the edge direction is enabled by mode.
REQ-020 Latency: sig stable from edge k onward SHALL produce the level/pulse update after edge k+SYNC_STAGES+max(filt_len,1)-1.
REQ-021 sticky SHALL set on pulse and clear on clr; simultaneous pulse and clr SHALL leave sticky set.
REQ-022 A mode change SHALL affect only level changes after the change; no retroactive pulse SHALL be emitted.
REQ-023 A filt_len change mid-count SHALL be compared against the counter immediately; if counter+1 is already at or above the new threshold, level SHALL update on the next edge.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.

Reset
REQ-025 While rst is high, all synchroniser flops, counters, level, pulse, sticky and any_pulse SHALL be 0 on each clock edge.
REQ-026 Reset mid-filter SHALL discard any partial count; an input held high through reset SHALL produce a rising event after full latency.

Structure
REQ-027 Mode encodings (MODE_NONE, MODE_RISE, MODE_FALL, MODE_BOTH) SHALL live in the shared package edge_det_pkg.
REQ-028 Per-channel logic (synchroniser, filter counter, edge detect, sticky) SHALL be sub-module edge_det_ch, instantiated NCH times by generate; any_pulse SHALL be registered in the top level from the next-state pulse vector.

Verification
REQ-029 Defaults, mode=11, filt_len=1; sig[0] rises at edge 10 -> pulse[0] and level[0] high after edge 12 only; sticky[0] set after edge 12; any_pulse=1 in the same cycle.
REQ-030 filt_len=5, mode=01; sig[1] high for 4 cycles then low -> no pulse, level[1] stays 0; held 5 cycles -> single pulse after edge k+6.
REQ-031 mode=10; sig[2] rises then falls with filt_len=1 -> pulse only on the fall; level[2] follows both edges.
REQ-032 sticky[3] set; clr[3] asserted in the same cycle as a new pulse[3] -> sticky[3] stays 1; clr[3] one cycle later with no pulse -> sticky[3]=0.
REQ-033 rst asserted mid-count (counter=3, filt_len=8) -> all outputs 0 after the edge; sig held high -> rising pulse 2+8 edges after rst deasserts.
REQ-034 All four channels toggle on the same edge, mode=11 -> all pulse bits high in one cycle, any_pulse=1 for exactly that cycle.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared definitions for the edge detector / glitch filter slice.
// Holds the edge-select mode encodings and the edge-enable helper.
package edge_det_pkg;

    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    // True when a level change in the given direction should raise a pulse.
    function automatic logic edge_enabled(input mode_e m, input logic rising);
        logic en;
        en = 1'b0;
        case (m)
            MODE_NONE: en = 1'b0;
            MODE_RISE: en = rising;
            MODE_FALL: en = ~rising;
            MODE_BOTH: en = 1'b1;
            default:   en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/edge_det_ch.sv
// One channel: synchroniser, stability filter, edge detect and sticky flag.
// pulse_nxt is exported so the top can register an aligned any_pulse.
module edge_det_ch
    import edge_det_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sig,
    input  mode_e             mode,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              clr,
    output logic              level,
    output logic              pulse,
    output logic              pulse_nxt,
    output logic              sticky
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [FILT_W-1:0]      cnt;
    logic [FILT_W:0]        thr;
    logic [FILT_W:0]        cnt_inc;
    logic                   accept;

    // One extra bit on thr/cnt_inc keeps the compare wrap-free at the top of range.
    always_comb begin
        s         = sync[SYNC_STAGES-1];
        thr       = (filt_len == '0) ? (FILT_W+1)'(1) : {1'b0, filt_len};
        cnt_inc   = {1'b0, cnt} + (FILT_W+1)'(1);
        accept    = (s != level) && (cnt_inc >= thr);
        pulse_nxt = accept && edge_enabled(mode, s);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            pulse  <= 1'b0;
            sticky <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig};
            if (s == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt_inc[FILT_W-1:0];
            end
            pulse <= pulse_nxt;
            // A clear arriving while the pulse is still visible must not erase it.
            sticky <= pulse_nxt | (sticky & (~clr | pulse));
        end
    end

endmodule

// File: rtl/edge_det_filt.sv
// Multi-channel filtered edge detector: NCH independent channels plus a
// registered any_pulse aligned with the per-channel pulse outputs.
module edge_det_filt
    import edge_det_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    sig,
    input  logic [1:0]        mode,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [NCH-1:0]    clr,
    output logic [NCH-1:0]    level,
    output logic [NCH-1:0]    pulse,
    output logic [NCH-1:0]    sticky,
    output logic              any_pulse
);

    mode_e          mode_sel;
    logic [NCH-1:0] pulse_nxt;

    always_comb begin
        mode_sel = mode_e'(mode);
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        edge_det_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_W     (FILT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .sig      (sig[i]),
            .mode     (mode_sel),
            .filt_len (filt_len),
            .clr      (clr[i]),
            .level    (level[i]),
            .pulse    (pulse[i]),
            .pulse_nxt(pulse_nxt[i]),
            .sticky   (sticky[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            any_pulse <= 1'b0;
        end else begin
            any_pulse <= |pulse_nxt;
        end
    end

endmodule

// File: tb/tb_edge_det_filt.sv
// Directed bench for edge_det_filt: a per-cycle vector table for the basic
// edge/mode behaviour plus hand-written multi-cycle corner sequences.
module tb_edge_det_filt;

    logic       clk;
    logic       rst;
    logic [3:0] sig;
    logic [1:0] mode;
    logic [3:0] filt_len;
    logic [3:0] clr;
    logic [3:0] level;
    logic [3:0] pulse;
    logic [3:0] sticky;
    logic       any_pulse;

    int checks;
    int failures;

    edge_det_filt #(
        .NCH        (4),
        .SYNC_STAGES(2),
        .FILT_W     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig      (sig),
        .mode     (mode),
        .filt_len (filt_len),
        .clr      (clr),
        .level    (level),
        .pulse    (pulse),
        .sticky   (sticky),
        .any_pulse(any_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sig;
        logic [1:0] mode;
        logic [3:0] clr;
        logic [3:0] level;
        logic [3:0] pulse;
        logic [3:0] sticky;
        logic       anyp;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sig = '0;
        clr = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        sig      = '0;
        mode     = 2'b11;
        filt_len = 4'd1;
        clr      = '0;

        // sig sampled at the row's edge; with 2 sync flops and filt_len=1 the
        // level/pulse update lands two rows later.
        tbl[0]  = '{4'b0000, 2'b11, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0001, 2'b11, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0001, 2'b11, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[3]  = '{4'b0001, 2'b11, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 1'b1};
        tbl[4]  = '{4'b0001, 2'b11, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b0};
        tbl[5]  = '{4'b0101, 2'b10, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b0};
        tbl[6]  = '{4'b0101, 2'b10, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b0};
        tbl[7]  = '{4'b0101, 2'b10, 4'b0000, 4'b0101, 4'b0000, 4'b0001, 1'b0};
        tbl[8]  = '{4'b0001, 2'b10, 4'b0000, 4'b0101, 4'b0000, 4'b0001, 1'b0};
        tbl[9]  = '{4'b0001, 2'b10, 4'b0000, 4'b0101, 4'b0000, 4'b0001, 1'b0};
        tbl[10] = '{4'b0001, 2'b10, 4'b0000, 4'b0001, 4'b0100, 4'b0101, 1'b1};
        tbl[11] = '{4'b0001, 2'b10, 4'b0000, 4'b0001, 4'b0000, 4'b0101, 1'b0};
        tbl[12] = '{4'b0001, 2'b10, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 1'b0};
        tbl[13] = '{4'b1110, 2'b11, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0};
        tbl[14] = '{4'b1110, 2'b11, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0};
        tbl[15] = '{4'b1110, 2'b11, 4'b0000, 4'b1110, 4'b1111, 4'b1111, 1'b1};
        tbl[16] = '{4'b1110, 2'b11, 4'b0000, 4'b1110, 4'b0000, 4'b1111, 1'b0};
        tbl[17] = '{4'b1111, 2'b00, 4'b0000, 4'b1110, 4'b0000, 4'b1111, 1'b0};
        tbl[18] = '{4'b1111, 2'b00, 4'b0000, 4'b1110, 4'b0000, 4'b1111, 1'b0};
        tbl[19] = '{4'b1111, 2'b01, 4'b0000, 4'b1111, 4'b0001, 4'b1111, 1'b1};
        tbl[20] = '{4'b1111, 2'b11, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 1'b0};

        // Reset state
        tick();
        tick();
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_pulse", 32'(pulse), 32'h0);
        chk("rst_sticky", 32'(sticky), 32'h0);
        chk("rst_any", 32'(any_pulse), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            sig  = tbl[i].sig;
            mode = tbl[i].mode;
            clr  = tbl[i].clr;
            tick();
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].level));
            chk($sformatf("tbl%0d_pulse", i), 32'(pulse), 32'(tbl[i].pulse));
            chk($sformatf("tbl%0d_sticky", i), 32'(sticky), 32'(tbl[i].sticky));
            chk($sformatf("tbl%0d_any", i), 32'(any_pulse), 32'(tbl[i].anyp));
        end

        // Short glitch rejected, then a 5-cycle hold accepted at edge k+6.
        do_reset();
        mode     = 2'b01;
        filt_len = 4'd5;
        for (int t = 1; t <= 4; t++) begin
            sig = 4'b0010;
            tick();
            chk("glitch_hi_pulse", 32'(pulse[1]), 32'h0);
            chk("glitch_hi_level", 32'(level[1]), 32'h0);
        end
        sig = 4'b0000;
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk("glitch_lo_pulse", 32'(pulse[1]), 32'h0);
            chk("glitch_lo_level", 32'(level[1]), 32'h0);
            chk("glitch_lo_sticky", 32'(sticky[1]), 32'h0);
        end
        sig = 4'b0010;
        for (int t = 1; t <= 9; t++) begin
            tick();
            chk($sformatf("hold5_t%0d_level", t), 32'(level[1]), 32'(t >= 7));
            chk($sformatf("hold5_t%0d_pulse", t), 32'(pulse[1]), 32'(t == 7));
            chk($sformatf("hold5_t%0d_any", t), 32'(any_pulse), 32'(t == 7));
        end
        chk("hold5_sticky", 32'(sticky[1]), 32'h1);

        // Sticky on ch3: clear coincident with a new pulse keeps it set.
        mode     = 2'b11;
        filt_len = 4'd1;
        sig      = 4'b1010;
        for (int t = 1; t <= 3; t++) tick();
        chk("st_rise_pulse", 32'(pulse[3]), 32'h1);
        chk("st_rise_sticky", 32'(sticky[3]), 32'h1);
        tick();
        chk("st_rise_after", 32'(pulse[3]), 32'h0);
        sig = 4'b0010;
        tick();
        tick();
        chk("st_fall_pre_sticky", 32'(sticky[3]), 32'h1);
        clr = 4'b1000;
        tick();
        chk("st_fall_pulse", 32'(pulse[3]), 32'h1);
        chk("st_clr_with_nxt", 32'(sticky[3]), 32'h1);
        tick();
        chk("st_clr_with_pulse", 32'(sticky[3]), 32'h1);
        tick();
        chk("st_clr_no_pulse", 32'(sticky[3]), 32'h0);
        chk("st_ch1_untouched", 32'(sticky[1]), 32'h1);
        clr = 4'b0000;

        // Reset with counter at 3, filt_len=8, input held high through it.
        do_reset();
        mode     = 2'b01;
        filt_len = 4'd8;
        sig      = 4'b0001;
        for (int t = 1; t <= 5; t++) begin
            tick();
            chk("midrst_pre_pulse", 32'(pulse[0]), 32'h0);
        end
        rst = 1'b1;
        tick();
        chk("midrst_level", 32'(level), 32'h0);
        chk("midrst_pulse", 32'(pulse), 32'h0);
        chk("midrst_sticky", 32'(sticky), 32'h0);
        chk("midrst_any", 32'(any_pulse), 32'h0);
        rst = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk($sformatf("postrst_t%0d_level", t), 32'(level[0]), 32'(t >= 10));
            chk($sformatf("postrst_t%0d_pulse", t), 32'(pulse[0]), 32'(t == 10));
        end

        // filt_len lowered from 8 to 3 with counter at 3: update on the next edge.
        mode = 2'b11;
        sig  = 4'b0101;
        for (int t = 1; t <= 5; t++) begin
            tick();
            chk($sformatf("fl_chg_t%0d_pulse", t), 32'(pulse[2]), 32'h0);
        end
        filt_len = 4'd3;
        tick();
        chk("fl_chg_pulse", 32'(pulse[2]), 32'h1);
        chk("fl_chg_level", 32'(level[2]), 32'h1);

        // filt_len=0 behaves as 1.
        filt_len = 4'd0;
        sig      = 4'b0001;
        for (int t = 1; t <= 3; t++) begin
            tick();
            chk($sformatf("fl0_t%0d_level", t), 32'(level[2]), 32'(t < 3));
            chk($sformatf("fl0_t%0d_pulse", t), 32'(pulse[2]), 32'(t == 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
